// File: rtl/csa_multibyte_sequencer_if.sv
// Bundle of operand, result and byte-adder signals for csa_multibyte_sequencer.
// The sequencer takes the slave view. The producer, consumer and adder take the master view.
interface csa_multibyte_sequencer_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_op, out_ready, add_sum, add_cout,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy, add_a, add_b, add_cin
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_op, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy, add_a, add_b, add_cin
    );
endinterface

// File: rtl/csa_multibyte_sequencer.sv
// Performs NBYTES-wide add/subtract one byte per clock through an external 8-bit adder.
// Subtraction is A + ~B + 1. B is inverted when the operands are captured.
module csa_multibyte_sequencer #(
    parameter int NBYTES = 4
) (
    input logic                     clk,
    input logic                     rst,
    csa_multibyte_sequencer_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [NBYTES-1:0][7:0]   op_a_q;
    logic [NBYTES-1:0][7:0]   op_b_q;
    logic [NBYTES-1:0][7:0]   res_q;
    logic [IW-1:0]            idx_q;
    logic                     carry_q;
    logic                     ovf_q;

    // NOTE: state is updated with non-blocking assignments, so every register
    // in this block samples the values that were present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    op_a_q  <= bus.in_a;
                    op_b_q  <= bus.in_op ? ~bus.in_b : bus.in_b;
                    carry_q <= bus.in_op ? 1'b1 : bus.in_cin;
                    idx_q   <= '0;
                end
                RUN: begin
                    res_q[idx_q] <= bus.add_sum;
                    carry_q      <= bus.add_cout;
                    if (idx_q == LAST) begin
                        // Signed overflow: both operands have the same sign and the result has the other sign.
                        ovf_q <= (op_a_q[NBYTES-1][7] == op_b_q[NBYTES-1][7]) &&
                                 (bus.add_sum[7] != op_a_q[NBYTES-1][7]);
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        bus.out_ovf   = 1'b0;
        bus.busy      = 1'b0;
        bus.add_a     = 8'h00;
        bus.add_b     = 8'h00;
        bus.add_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                bus.busy    = 1'b1;
                bus.add_a   = op_a_q[idx_q];
                bus.add_b   = op_b_q[idx_q];
                bus.add_cin = carry_q;
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_sum   = W'(res_q);
                bus.out_cout  = carry_q;
                bus.out_ovf   = ovf_q;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_csa_multibyte_sequencer.sv
// Directed bench for csa_multibyte_sequencer at NBYTES=4 and NBYTES=2.
// A behavioural byte adder is connected to each instance.
module tb_csa_multibyte_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_multibyte_sequencer_if #(.NBYTES(4)) if4 ();
    csa_multibyte_sequencer_if #(.NBYTES(2)) if2 ();

    assign {if4.add_cout, if4.add_sum} = 9'(if4.add_a) + 9'(if4.add_b) + 9'(if4.add_cin);
    assign {if2.add_cout, if2.add_sum} = 9'(if2.add_a) + 9'(if2.add_b) + 9'(if2.add_cin);

    csa_multibyte_sequencer #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    csa_multibyte_sequencer #(.NBYTES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: returns {ovf, cout, sum}.
    function automatic logic [33:0] model(input int nb, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic op);
        logic [63:0] mask, aa, bb, s;
        logic [31:0] sum;
        int w;
        w    = 8 * nb;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = (op ? ~{32'd0, b} : {32'd0, b}) & mask;
        s    = aa + bb + (op ? 64'd1 : {63'd0, cin});
        sum  = 32'(s & mask);
        return {(aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]), s[w], sum};
    endfunction

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic op);
        if4.in_a = a; if4.in_b = b; if4.in_cin = cin; if4.in_op = op;
        if4.in_valid = 1'b1;
        check("accept_ready", 64'(if4.in_ready), 64'd1);
        step();
        if4.in_valid = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (if4.out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic finish4(input string tag, input logic [31:0] sum, input logic cout, input logic ovf);
        check({tag, "_sum"},  64'(if4.out_sum),  64'(sum));
        check({tag, "_cout"}, 64'(if4.out_cout), 64'(cout));
        check({tag, "_ovf"},  64'(if4.out_ovf),  64'(ovf));
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(if4.out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(if4.in_ready),  64'd1);
    endtask

    initial begin
        int lat;
        int n;
        int acc [4];
        logic [31:0] ra, rb;
        logic rc, rop;
        logic [33:0] exp;

        rst = 1'b1;
        {if4.in_valid, if4.in_a, if4.in_b, if4.in_cin, if4.in_op, if4.out_ready} = '0;
        {if2.in_valid, if2.in_a, if2.in_b, if2.in_cin, if2.in_op, if2.out_ready} = '0;
        step(); step();
        rst = 1'b0;

        check("rst_in_ready",  64'(if4.in_ready),  64'd1);
        check("rst_out_valid", 64'(if4.out_valid), 64'd0);
        check("rst_out_sum",   64'(if4.out_sum),   64'd0);
        check("rst_out_flags", 64'({if4.out_cout, if4.out_ovf}), 64'd0);
        check("rst_busy",      64'(if4.busy),      64'd0);
        check("rst_add",       64'({if4.add_a, if4.add_b, if4.add_cin}), 64'd0);
        check("rst2_in_ready", 64'(if2.in_ready),  64'd1);

        // Carry ripples through all four bytes; out_valid appears NBYTES edges after acceptance.
        start4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("run_busy",     64'(if4.busy),     64'd1);
        check("run_in_ready", 64'(if4.in_ready), 64'd0);
        check("run_add0",     64'({if4.add_a, if4.add_b, if4.add_cin}), 64'({8'hFF, 8'h01, 1'b0}));
        wait4(lat);
        check("latency", 64'(lat), 64'd4);
        finish4("add_wrap", 32'h0000_0000, 1'b1, 1'b0);

        start4(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        check("sub_add0", 64'({if4.add_a, if4.add_b, if4.add_cin}), 64'({8'h05, 8'hF8, 1'b1}));
        wait4(lat);
        finish4("sub_5m7", 32'hFFFF_FFFE, 1'b0, 1'b0);

        start4(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        wait4(lat);
        finish4("sub_7m5", 32'h0000_0002, 1'b1, 1'b0);

        start4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait4(lat);
        finish4("add_ovf", 32'h8000_0000, 1'b0, 1'b1);

        start4(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait4(lat);
        finish4("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: a new request is pending while the result is stalled.
        start4(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        wait4(lat);
        if4.in_a = 32'h0000_0001; if4.in_b = 32'h0000_0002; if4.in_cin = 1'b0; if4.in_op = 1'b0;
        if4.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid",    64'(if4.out_valid), 64'd1);
            check("bp_sum",      64'(if4.out_sum),   64'h31);
            check("bp_flags",    64'({if4.out_cout, if4.out_ovf}), 64'd0);
            check("bp_in_ready", 64'(if4.in_ready),  64'd0);
            step();
        end
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
        check("bp_idle_ready", 64'(if4.in_ready), 64'd1);
        check("bp_idle_busy",  64'(if4.busy),     64'd0);
        step();
        if4.in_valid = 1'b0;
        check("bp_accepted", 64'(if4.busy), 64'd1);
        wait4(lat);
        finish4("bp_next", 32'h0000_0003, 1'b0, 1'b0);

        // Reset while idx == 2.
        start4(32'hAABB_CCDD, 32'h0102_0304, 1'b0, 1'b0);
        step(); step();
        check("mid_idx2", 64'(if4.add_a), 64'hBB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_in_ready",  64'(if4.in_ready),  64'd1);
        check("mid_out_valid", 64'(if4.out_valid), 64'd0);
        check("mid_busy",      64'(if4.busy),      64'd0);
        check("mid_add",       64'({if4.add_a, if4.add_b, if4.add_cin}), 64'd0);
        step();
        check("mid_no_output", 64'(if4.out_valid), 64'd0);
        start4(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        wait4(lat);
        finish4("after_rst", 32'h2345_678A, 1'b0, 1'b0);

        // Back-to-back, NBYTES=4.
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rop = 1'($urandom_range(0, 1));
            if4.in_a = ra; if4.in_b = rb; if4.in_cin = rc; if4.in_op = rop;
            exp = model(4, ra, rb, rc, rop);
            n = 0;
            while (if4.in_ready !== 1'b1 && n < 20) begin step(); n++; end
            step();
            acc[i] = cyc;
            wait4(lat);
            check("b2b4_result", 64'({if4.out_ovf, if4.out_cout, if4.out_sum}), 64'(exp));
            if (i > 0) check("b2b4_spacing", 64'(acc[i] - acc[i-1]), 64'd6);
        end
        if4.in_valid = 1'b0;
        step();
        if4.out_ready = 1'b0;
        check("b2b4_idle", 64'(if4.in_ready), 64'd1);

        // Back-to-back, NBYTES=2.
        if2.out_ready = 1'b1;
        if2.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = {16'd0, 16'($urandom)}; rb = {16'd0, 16'($urandom)};
            rc = 1'($urandom_range(0, 1)); rop = 1'($urandom_range(0, 1));
            if2.in_a = ra[15:0]; if2.in_b = rb[15:0]; if2.in_cin = rc; if2.in_op = rop;
            exp = model(2, ra, rb, rc, rop);
            n = 0;
            while (if2.in_ready !== 1'b1 && n < 20) begin step(); n++; end
            step();
            acc[i] = cyc;
            n = 0;
            while (if2.out_valid !== 1'b1 && n < 20) begin step(); n++; end
            check("b2b2_latency", 64'(n), 64'd2);
            check("b2b2_result", 64'({if2.out_ovf, if2.out_cout, if2.out_sum}),
                  64'({exp[33:32], exp[15:0]}));
            if (i > 0) check("b2b2_spacing", 64'(acc[i] - acc[i-1]), 64'd4);
        end
        if2.in_valid = 1'b0;
        step();
        if2.out_ready = 1'b0;
        check("b2b2_idle", 64'(if2.in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
